// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with a per-register busy scoreboard for operand stalls.
// Optional write-first forwarding on both read ports is enabled by defining RF_BYPASS_EN.
module reg_file_2r1w #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                rs1_en,
  input  logic                rs2_en,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  input  logic                we,
  input  logic [ADDR_W-1:0]   rd,
  input  logic [DATA_W-1:0]   wd,
  input  logic                mark_en,
  input  logic [ADDR_W-1:0]   mark_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [DATA_W-1:0]   a_raw;
  logic [DATA_W-1:0]   b_raw;
  logic                a_busy;
  logic                b_busy;
  logic                a_mask;
  logic                b_mask;

  // A mark and a write landing on the same register leave it busy: the mark is a newer producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && rd == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
          regs[i] <= wd;
        end
        if (ZERO_REG != 0 && i == 0) begin
          busy_q[i] <= 1'b0;
        end else if (mark_en && mark_rd == ADDR_W'(i)) begin
          busy_q[i] <= 1'b1;
        end else if (we && rd == ADDR_W'(i)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    a_raw  = '0;
    b_raw  = '0;
    a_busy = 1'b0;
    b_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (rs1 == ADDR_W'(i)) begin
          a_raw  = regs[i];
          a_busy = busy_q[i];
        end
        if (rs2 == ADDR_W'(i)) begin
          b_raw  = regs[i];
          b_busy = busy_q[i];
        end
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic wr_live;
  logic a_fwd;
  logic b_fwd;

  // A forwarded operand is not stalled on, unless a new producer is being marked on the same edge.
  always_comb begin
    wr_live = we && ({1'b0, rd} < (ADDR_W + 1)'(NUM_REGS)) && !(ZERO_REG != 0 && rd == '0);
    a_fwd   = wr_live && (rs1 == rd);
    b_fwd   = wr_live && (rs2 == rd);
    a_mask  = a_fwd && !(mark_en && mark_rd == rs1);
    b_mask  = b_fwd && !(mark_en && mark_rd == rs2);
    A       = a_fwd ? wd : a_raw;
    B       = b_fwd ? wd : b_raw;
  end
`else
  always_comb begin
    a_mask = 1'b0;
    b_mask = 1'b0;
    A      = a_raw;
    B      = b_raw;
  end
`endif

  assign stall = (rs1_en && a_busy && !a_mask) || (rs2_en && b_busy && !b_mask);
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: a 4-register instance and a 3-register ZERO_REG=1 instance
// share stimulus and are compared against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_file_2r1w;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rs1, rs2, rd, mark_rd;
  logic       rs1_en, rs2_en, we, mark_en;
  logic [7:0] wd;
  logic [7:0] a0, b0, a1, b1;
  logic       stall0, stall1;
  logic [3:0] busy0;
  logic [2:0] busy1;

  int errors = 0;
  int checks = 0;

  int         nr[2] = '{4, 3};
  bit         zr[2] = '{1'b0, 1'b1};
  logic [7:0] mreg [2][4];
  bit         mbusy[2][4];

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file_2r1w #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .A(a0), .B(b0), .we(we), .rd(rd), .wd(wd), .mark_en(mark_en), .mark_rd(mark_rd),
    .stall(stall0), .busy(busy0)
  );

  reg_file_2r1w #(.DATA_W(8), .NUM_REGS(3), .ZERO_REG(1)) dutz (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .A(a1), .B(b1), .we(we), .rd(rd), .wd(wd), .mark_en(mark_en), .mark_rd(mark_rd),
    .stall(stall1), .busy(busy1)
  );

  function automatic void model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        mreg[k][i]  = 8'h00;
        mbusy[k][i] = 1'b0;
      end
  endfunction

  // Write first, then let a mark override the clear so a new producer keeps the register busy.
  function automatic void model_update();
    for (int k = 0; k < 2; k++) begin
      if (we && int'(rd) < nr[k]) begin
        if (!(zr[k] && rd == 2'd0)) mreg[k][rd] = wd;
        mbusy[k][rd] = 1'b0;
      end
      if (mark_en && int'(mark_rd) < nr[k] && !(zr[k] && mark_rd == 2'd0)) mbusy[k][mark_rd] = 1'b1;
    end
  endfunction

  function automatic logic [7:0] exp_data(int k, int idx);
    if (idx >= nr[k] || (zr[k] && idx == 0)) return 8'h00;
    if (BYP && we && int'(rd) == idx) return wd;
    return mreg[k][idx];
  endfunction

  function automatic logic exp_port_stall(int k, int idx, logic en);
    if (!en || idx >= nr[k]) return 1'b0;
    if (BYP && we && int'(rd) == idx && !(zr[k] && idx == 0) && !(mark_en && int'(mark_rd) == idx))
      return 1'b0;
    return mbusy[k][idx];
  endfunction

  function automatic logic [3:0] exp_busy(int k);
    logic [3:0] v = 4'h0;
    for (int i = 0; i < nr[k]; i++) v[i] = mbusy[k][i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rs1 = 2'd1; rs2 = 2'd3; rs1_en = 1'b1; rs2_en = 1'b1;
    #1;
    checks++; if ({a0, b0, stall0, busy0} !== 21'd0) begin errors++;
      $display("[TB] FAIL reset_in_dut0: A=%h B=%h stall=%b busy=%b want all 0", a0, b0, stall0, busy0); end
    checks++; if ({a1, b1, stall1, busy1} !== 20'd0) begin errors++;
      $display("[TB] FAIL reset_in_dutz: A=%h B=%h stall=%b busy=%b want all 0", a1, b1, stall1, busy1); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({a0, b0, stall0, busy0} !== 21'd0) begin errors++;
      $display("[TB] FAIL reset_out_dut0: A=%h B=%h stall=%b busy=%b want all 0", a0, b0, stall0, busy0); end
    checks++; if ({a1, b1, stall1, busy1} !== 20'd0) begin errors++;
      $display("[TB] FAIL reset_out_dutz: A=%h B=%h stall=%b busy=%b want all 0", a1, b1, stall1, busy1); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; rd = 2'(i); wd = 8'(8'h11 * (i + 1));
      tick();
    end
    we = 1'b0; rs1 = 2'd2; rs2 = 2'd3;
    #1;
    checks++; if (a0 !== 8'h33) begin errors++; $display("[TB] FAIL wr_rd_A0: got %h want 33", a0); end
    checks++; if (b0 !== 8'h44) begin errors++; $display("[TB] FAIL wr_rd_B0: got %h want 44", b0); end
    checks++; if (a1 !== 8'h33) begin errors++; $display("[TB] FAIL wr_rd_Az: got %h want 33", a1); end
    checks++; if (b1 !== 8'h00) begin errors++; $display("[TB] FAIL oor_read_Bz: got %h want 00", b1); end
    rs1 = 2'd0;
    #1;
    checks++; if (a0 !== 8'h11) begin errors++; $display("[TB] FAIL reg0_A0: got %h want 11", a0); end
    checks++; if (a1 !== 8'h00) begin errors++; $display("[TB] FAIL zero_reg_Az: got %h want 00", a1); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] want;
    want = BYP ? 8'hA5 : 8'h22;
    rs1 = 2'd1; we = 1'b1; rd = 2'd1; wd = 8'hA5;
    #1;
    checks++; if (a0 !== want) begin errors++; $display("[TB] FAIL same_cyc_A0: got %h want %h", a0, want); end
    checks++; if (a1 !== want) begin errors++; $display("[TB] FAIL same_cyc_Az: got %h want %h", a1, want); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (a0 !== 8'hA5) begin errors++; $display("[TB] FAIL next_cyc_A0: got %h want a5", a0); end
    checks++; if (a1 !== 8'hA5) begin errors++; $display("[TB] FAIL next_cyc_Az: got %h want a5", a1); end
  endtask

  task automatic test_scoreboard();
    logic want;
    rs1_en = 1'b0; rs2_en = 1'b0; mark_en = 1'b1; mark_rd = 2'd2;
    tick();
    mark_en = 1'b0; rs1 = 2'd2; rs1_en = 1'b1;
    #1;
    checks++; if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL sb_stall0: got %b want 1", stall0); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL sb_stallz: got %b want 1", stall1); end
    checks++; if (busy0 !== 4'b0100) begin errors++; $display("[TB] FAIL sb_busy0: got %b want 0100", busy0); end
    checks++; if (busy1 !== 3'b100) begin errors++; $display("[TB] FAIL sb_busyz: got %b want 100", busy1); end
    rs1_en = 1'b0;
    #1;
    checks++; if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL sb_unused0: got %b want 0", stall0); end
    rs1_en = 1'b1; we = 1'b1; rd = 2'd2; wd = 8'h77;
    #1;
    want = BYP ? 1'b0 : 1'b1;
    checks++; if (stall0 !== want) begin errors++; $display("[TB] FAIL sb_wr_stall0: got %b want %b", stall0, want); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (busy0 !== 4'b0000) begin errors++; $display("[TB] FAIL sb_clr_busy0: got %b want 0000", busy0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL sb_clr_stall0: got %b want 0", stall0); end
    checks++; if (a0 !== 8'h77) begin errors++; $display("[TB] FAIL sb_clr_A0: got %h want 77", a0); end
  endtask

  task automatic test_collision();
    mark_en = 1'b1; mark_rd = 2'd3; we = 1'b1; rd = 2'd3; wd = 8'h5A;
    tick();
    mark_en = 1'b0; we = 1'b0; rs1 = 2'd3; rs1_en = 1'b0;
    #1;
    checks++; if (busy0 !== 4'b1000) begin errors++; $display("[TB] FAIL coll_busy0: got %b want 1000", busy0); end
    checks++; if (a0 !== 8'h5A) begin errors++; $display("[TB] FAIL coll_A0: got %h want 5a", a0); end
    checks++; if (busy1 !== 3'b000) begin errors++; $display("[TB] FAIL oor_busyz: got %b want 000", busy1); end
    mark_en = 1'b1; mark_rd = 2'd0;
    tick();
    mark_en = 1'b0; rs1 = 2'd0; rs1_en = 1'b1;
    #1;
    checks++; if (busy0 !== 4'b1001) begin errors++; $display("[TB] FAIL mark0_busy0: got %b want 1001", busy0); end
    checks++; if (busy1 !== 3'b000) begin errors++; $display("[TB] FAIL mark0_busyz: got %b want 000", busy1); end
    checks++; if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL mark0_stall0: got %b want 1", stall0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL mark0_stallz: got %b want 0", stall1); end
  endtask

  task automatic test_async_reset();
    rs1 = 2'd3; rs2 = 2'd1; rs1_en = 1'b1; rs2_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a0, b0} !== 16'h0000) begin errors++; $display("[TB] FAIL arst_data0: A=%h B=%h want 00 00", a0, b0); end
    checks++; if ({busy0, stall0} !== 5'd0) begin errors++; $display("[TB] FAIL arst_sb0: busy=%b stall=%b want 0", busy0, stall0); end
    checks++; if ({b1, busy1} !== 11'd0) begin errors++; $display("[TB] FAIL arst_z: B=%h busy=%b want 0", b1, busy1); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({a0, b0, stall0, busy0} !== 21'd0) begin errors++;
      $display("[TB] FAIL arst_rel0: A=%h B=%h stall=%b busy=%b want all 0", a0, b0, stall0, busy0); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ga, gb;
    logic       gs;
    logic [3:0] gbusy;
    for (int n = 0; n < 300; n++) begin
      rs1 = 2'($urandom_range(0, 3)); rs2 = 2'($urandom_range(0, 3));
      rs1_en = 1'($urandom_range(0, 1)); rs2_en = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) != 0); rd = 2'($urandom_range(0, 3)); wd = 8'($urandom);
      mark_en = ($urandom_range(0, 2) == 0); mark_rd = 2'($urandom_range(0, 3));
      #1;
      for (int k = 0; k < 2; k++) begin
        ga    = (k == 0) ? a0 : a1;
        gb    = (k == 0) ? b0 : b1;
        gs    = (k == 0) ? stall0 : stall1;
        gbusy = (k == 0) ? busy0 : {1'b0, busy1};
        checks++; if (ga !== exp_data(k, int'(rs1))) begin errors++;
          $display("[TB] FAIL rnd_A inst%0d it%0d: got %h want %h", k, n, ga, exp_data(k, int'(rs1))); end
        checks++; if (gb !== exp_data(k, int'(rs2))) begin errors++;
          $display("[TB] FAIL rnd_B inst%0d it%0d: got %h want %h", k, n, gb, exp_data(k, int'(rs2))); end
        checks++; if (gs !== (exp_port_stall(k, int'(rs1), rs1_en) | exp_port_stall(k, int'(rs2), rs2_en))) begin errors++;
          $display("[TB] FAIL rnd_stall inst%0d it%0d: got %b want %b", k, n, gs,
                   exp_port_stall(k, int'(rs1), rs1_en) | exp_port_stall(k, int'(rs2), rs2_en)); end
        checks++; if (gbusy !== exp_busy(k)) begin errors++;
          $display("[TB] FAIL rnd_busy inst%0d it%0d: got %b want %b", k, n, gbusy, exp_busy(k)); end
      end
      tick();
    end
    we = 1'b0; mark_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    rs1 = '0; rs2 = '0; rs1_en = 1'b0; rs2_en = 1'b0;
    we = 1'b0; rd = '0; wd = '0; mark_en = 1'b0; mark_rd = '0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_same_cycle();
    test_scoreboard();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file with two combinational read ports and one synchronous write port, replacing the fixed 4x8-bit dual-operand selector in the sCPU datapath. It stores NUM_REGS registers of DATA_W bits and drives operands A and B to the ALU. A per-register busy scoreboard flags reads of registers with an outstanding write, so the control FSM can stall. It sits between the decoder (rs1/rs2/rd fields) and the ALU/writeback path.

## Interface
- DATA_W, 8, register and operand width
- NUM_REGS, 4, number of architectural registers (2..256)
- ADDR_W, $clog2(NUM_REGS), register index width
- ZERO_REG, 0, 1 = register 0 is hardwired to zero

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs1  in  ADDR_W  read index, port A
- rs2  in  ADDR_W  read index, port B
- rs1_en  in  1  port A operand is used this cycle (stall qualification)
- rs2_en  in  1  port B operand is used this cycle (stall qualification)
- A  out  DATA_W  register[rs1]
- B  out  DATA_W  register[rs2]
- we  in  1  write enable
- rd  in  ADDR_W  write index
- wd  in  DATA_W  write data
- mark_en  in  1  mark register mark_rd busy (pending write issued)
- mark_rd  in  ADDR_W  register to mark busy
- stall  out  1  a used operand is busy
- busy  out  NUM_REGS  scoreboard bit vector, bit i = register i pending

## Operation
- Storage: NUM_REGS x DATA_W flops, no RAM inference required.
- Write: on rising clk with we=1 and rd < NUM_REGS, reg[rd] <= wd. rd >= NUM_REGS: write dropped, no other effect.
- Read: A/B are combinational from rs1/rs2. Index >= NUM_REGS reads 0.
- ZERO_REG=1: reg0 always reads 0, writes to 0 dropped, mark of 0 ignored, busy[0] stays 0.
- Scoreboard per register i, next-state:
  - mark_en && mark_rd==i -> busy[i] <= 1
  - else we && rd==i -> busy[i] <= 0
  - else hold
  - Simultaneous mark and write to the same register: mark wins (a new producer was issued), busy stays 1, data is still written.
- stall = (rs1_en && busy[rs1]) || (rs2_en && busy[rs2]); out-of-range index contributes 0.
- stall has no internal effect; the control FSM is responsible for holding the instruction.

## Timing
- Reset (rst_n=0, asynchronous): every register = 0, busy = 0, hence A = 0, B = 0, stall = 0 while in reset and immediately after release.
- Reset asserted mid-operation clears data and scoreboard in the same instant; a write on the same edge as reset release is ignored.
- Write latency: 1 clk; data visible on A/B in the cycle after the write edge (without bypass).
- Read latency: 0 clk (combinational from rs1/rs2 and stored state).
- Busy set/clear: 1 clk after the mark/write edge; stall follows combinationally.
- Same-cycle read of rd while we=1: see Configuration.

## Configuration
- Macro RF_BYPASS_EN.
- Defined: write-first forwarding. When we=1 and rs1==rd (or rs2==rd), A (or B) = wd in the same cycle; and the busy term for that port is masked, so stall does not assert for a register being written this cycle (unless mark_en also targets it). ZERO_REG still forces reg0 to 0.
- Not defined: read-old. A/B show the pre-write value; stall uses the registered busy bit only. No added combinational path from wd to A/B.

## Test plan
- Reset: hold rst_n=0, set rs1=1, rs2=3 -> A=0x00, B=0x00, stall=0, busy=0; release, same outputs.
- Write/read all: write reg i = 0x11*(i+1) for i=0..3, then rs1=2, rs2=3 -> A=0x33, B=0x44 (ZERO_REG=0); with ZERO_REG=1 rs1=0 -> A=0x00.
- Same-cycle read: we=1, rd=1, wd=0xA5, rs1=1 -> A=0xA5 with RF_BYPASS_EN, old value 0x22 without; next cycle A=0xA5 in both.
- Scoreboard: mark_en, mark_rd=2; next cycle rs1=2, rs1_en=1 -> stall=1; rs1_en=0 -> stall=0; we, rd=2 -> busy[2]=0 next cycle, stall=0.
- Mark/write collision: mark_en, mark_rd=3 and we, rd=3, wd=0x5A on one edge -> busy[3]=1, reg3=0x5A.
- Async reset mid-run: after writes and marks, pulse rst_n low between edges -> all regs 0 and busy=0 immediately, without waiting for clk.
